// File: rtl/tp_disp_pkg.sv
// Shared definitions for the nibble display sequencer.
//   state_e    : sequencer states (IDLE / SHOW / GAP)
//   DP_BIT     : decimal-point bit position inside the 5-bit decoder code
//   NIB_W      : width of one displayed hex nibble
//   BLANK_CODE : decoder code driven while nothing has been shown yet
//   mk_code()  : packs {dp, nibble} into a decoder code
package tp_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int          DP_BIT     = 4;
  localparam int          NIB_W      = 4;
  localparam logic [4:0]  BLANK_CODE = 5'h00;

  function automatic logic [4:0] mk_code(input logic dp, input logic [NIB_W-1:0] nib);
    logic [4:0] c;
    c                = BLANK_CODE;
    c[DP_BIT]        = dp;
    c[NIB_W-1:0]     = nib;
    return c;
  endfunction

endpackage

// File: rtl/seg_hold_timer.sv
// Interval down-counter shared by the HOLD and GAP intervals.
//   clk, rst     : clock, synchronous active-high reset (cnt -> 0)
//   load_i       : load load_val_i into the counter this edge
//   load_val_i   : interval length in cycles
//   expire_o     : high during the final cycle of the interval (cnt == 1)
// Counts down to 0 and stops there; it never wraps.
module seg_hold_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                 cnt_d = load_val_i;
    else if (cnt_q != '0)       cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/seg_nibble_seq.sv
// Feeds a single-digit seven-segment decoder one hex nibble at a time,
// MSB nibble first, each held HOLD_CYCLES cycles with GAP_CYCLES blank
// cycles between nibbles. The MSB nibble carries the decimal point.
//   clk, rst    : clock, synchronous active-high reset
//   load_valid  : value offered;  load_data : value to display
//   load_ready  : value can be accepted (IDLE or final cycle of a pass)
//   disp_code   : registered {dp, nibble} to the decoder
//   disp_blank  : registered; segments must be blanked
//   busy        : sequence in progress
//   done        : one-cycle pulse in the final cycle of a pass
// Build option SEG_SEQ_REPEAT_EN: the held value is replayed forever
// (with a gap between passes) instead of returning to IDLE.
module seg_nibble_seq
  import tp_disp_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic [4:0]        disp_code,
  output logic              disp_blank,
  output logic              busy,
  output logic              done
);

  localparam int NIB     = DATA_W / NIB_W;
  localparam int IDX_W   = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] ZERO_LD = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);
  // Interval following a nibble: a gap if configured, else the next hold.
  localparam logic [CNT_W-1:0] POST_LD = (GAP_CYCLES > 0) ? GAP_LD : HOLD_LD;

`ifdef SEG_SEQ_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  state_e             state_q;
  logic [DATA_W-1:0]  sr_q;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic [4:0]         code_q;
  logic               blank_q;

  logic               tmr_load, expire, last, accept;
  logic [CNT_W-1:0]   tmr_val;

  function automatic logic [NIB_W-1:0] nib_at(input logic [IDX_W-1:0] i);
    logic [DATA_W-1:0] s;
    s = sr_q >> (NIB_W * (NIB - 1 - int'(i)));
    return s[NIB_W-1:0];
  endfunction

  assign last       = (idx_q == IDX_W'(NIB - 1));
  assign idx_nxt    = last ? '0 : idx_q + 1'b1;
  assign done       = (state_q == ST_SHOW) && last && expire;
  assign load_ready = (state_q == ST_IDLE) || done;
  assign accept     = load_valid && load_ready;
  assign busy       = (state_q != ST_IDLE);
  assign disp_code  = code_q;
  assign disp_blank = blank_q;

  // Timer reloads on every state entry; an accept restarts the hold.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = ZERO_LD;
    if (accept) begin
      tmr_load = 1'b1;
      tmr_val  = HOLD_LD;
    end else if (expire) begin
      tmr_load = 1'b1;
      unique case (state_q)
        ST_SHOW: tmr_val = (!last || REPEAT) ? POST_LD : ZERO_LD;
        ST_GAP:  tmr_val = HOLD_LD;
        default: tmr_val = ZERO_LD;
      endcase
    end
  end

  seg_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      code_q  <= BLANK_CODE;
      blank_q <= 1'b1;
    end else if (accept) begin
      // Show the top nibble straight from load_data so it appears at the accept edge.
      state_q <= ST_SHOW;
      sr_q    <= load_data;
      idx_q   <= '0;
      code_q  <= mk_code(1'b1, load_data[DATA_W-1 -: NIB_W]);
      blank_q <= 1'b0;
    end else if (expire) begin
      unique case (state_q)
        ST_SHOW: begin
          if (last && !REPEAT) begin
            state_q <= ST_IDLE;
            blank_q <= 1'b1;
          end else if (GAP_CYCLES > 0) begin
            // Index advances on gap entry; the gap keeps the old code.
            state_q <= ST_GAP;
            idx_q   <= idx_nxt;
            blank_q <= 1'b1;
          end else begin
            idx_q   <= idx_nxt;
            code_q  <= mk_code(idx_nxt == '0, nib_at(idx_nxt));
          end
        end
        ST_GAP: begin
          state_q <= ST_SHOW;
          code_q  <= mk_code(idx_q == '0, nib_at(idx_q));
          blank_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_nibble_seq.sv
module tb_seg_nibble_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // A: DATA_W=8 HOLD=4 GAP=2; B: DATA_W=16 HOLD=4 GAP=0; C: DATA_W=8 HOLD=1 GAP=0
  logic        a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
  logic [7:0]  a_data = '0, c_data = '0;
  logic [15:0] b_data = '0;
  logic        a_ready, b_ready, c_ready;
  logic [4:0]  a_code, b_code, c_code;
  logic        a_blank, b_blank, c_blank, a_busy, b_busy, c_busy, a_done, b_done, c_done;

  seg_nibble_seq #(.DATA_W(8), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .load_valid(a_valid), .load_data(a_data), .load_ready(a_ready),
    .disp_code(a_code), .disp_blank(a_blank), .busy(a_busy), .done(a_done));

  seg_nibble_seq #(.DATA_W(16), .HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .load_valid(b_valid), .load_data(b_data), .load_ready(b_ready),
    .disp_code(b_code), .disp_blank(b_blank), .busy(b_busy), .done(b_done));

  seg_nibble_seq #(.DATA_W(8), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst), .load_valid(c_valid), .load_data(c_data), .load_ready(c_ready),
    .disp_code(c_code), .disp_blank(c_blank), .busy(c_busy), .done(c_done));

  // Reference: per-cycle expected {code, blank, done} for one pass, starting
  // the cycle after the accept edge.
  typedef struct packed { logic [4:0] code; logic blank; logic done; } exp_t;
  exp_t exp_q[$];

  function automatic void build_exp(input int dw, input int hold, input int gap,
                                    input logic [15:0] v, input bit rep);
    int         nib;
    logic [4:0] code;
    exp_t       e;
    nib  = dw / 4;
    code = 5'h00;
    for (int n = 0; n < nib; n++) begin
      code = {(n == 0) ? 1'b1 : 1'b0, 4'((v >> (4 * (nib - 1 - n))) & 16'hF)};
      for (int h = 0; h < hold; h++) begin
        e.code = code; e.blank = 1'b0; e.done = (n == nib - 1) && (h == hold - 1);
        exp_q.push_back(e);
      end
      if (n < nib - 1 || rep)
        for (int g = 0; g < gap; g++) begin
          e.code = code; e.blank = 1'b1; e.done = 1'b0;
          exp_q.push_back(e);
        end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_code, a_blank, a_busy, a_done, a_ready} !== {5'h00, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_a got code=%h blank=%b busy=%b done=%b ready=%b want 00 1 0 0 1",
               a_code, a_blank, a_busy, a_done, a_ready);
    end
    checks++;
    if ({b_code, b_blank, b_busy, b_done, b_ready, c_code, c_blank, c_busy, c_done, c_ready}
        !== {5'h00, 4'b1001, 5'h00, 4'b1001}) begin
      failures++;
      $display("FAIL reset_bc got b=%h%b%b%b%b c=%h%b%b%b%b want 00 1001 each",
               b_code, b_blank, b_busy, b_done, b_ready, c_code, c_blank, c_busy, c_done, c_ready);
    end
    rst = 1'b0;
  endtask

  // One pass on A; checks every cycle, then the idle cycle afterwards.
  task automatic test_single_a(input logic [7:0] v);
    exp_q.delete();
    build_exp(8, 4, 2, {8'h00, v}, 1'b0);
    checks++;
    if (a_ready !== 1'b1) begin
      failures++; $display("FAIL a_ready_before got %b want 1", a_ready);
    end
    a_valid = 1'b1; a_data = v;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      checks++;
      if ({a_code, a_blank, a_done, a_ready, a_busy} !==
          {exp_q[c].code, exp_q[c].blank, exp_q[c].done, exp_q[c].done, 1'b1}) begin
        failures++;
        $display("FAIL a_seq v=%h cyc=%0d got code=%h blank=%b done=%b ready=%b busy=%b want code=%h blank=%b done=%b",
                 v, c + 1, a_code, a_blank, a_done, a_ready, a_busy, exp_q[c].code, exp_q[c].blank, exp_q[c].done);
      end
      if (c == 0) begin a_valid = 1'b0; a_data = 8'($urandom); end
    end
    @(negedge clk);
    checks++;
    if ({a_blank, a_busy, a_done, a_ready} !== 4'b1001) begin
      failures++;
      $display("FAIL a_idle_after v=%h got blank=%b busy=%b done=%b ready=%b want 1 0 0 1",
               v, a_blank, a_busy, a_done, a_ready);
    end
  endtask

  // load_valid held through a pass with new data: taken only at done, no idle cycle.
  task automatic test_back_to_back(input logic [7:0] v1, input logic [7:0] v2);
    exp_q.delete();
    build_exp(8, 4, 2, {8'h00, v1}, 1'b0);
    build_exp(8, 4, 2, {8'h00, v2}, 1'b0);
    a_valid = 1'b1; a_data = v1;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      checks++;
      if ({a_code, a_blank, a_done, a_ready, a_busy} !==
          {exp_q[c].code, exp_q[c].blank, exp_q[c].done, exp_q[c].done, 1'b1}) begin
        failures++;
        $display("FAIL b2b v=%h/%h cyc=%0d got code=%h blank=%b done=%b ready=%b busy=%b want code=%h blank=%b done=%b",
                 v1, v2, c + 1, a_code, a_blank, a_done, a_ready, a_busy, exp_q[c].code, exp_q[c].blank, exp_q[c].done);
      end
      if (c == 0)  a_data = v2;
      if (c == 10) a_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({a_busy, a_ready} !== 2'b01) begin
      failures++; $display("FAIL b2b_idle got busy=%b ready=%b want 0 1", a_busy, a_ready);
    end
  endtask

  task automatic test_mid_reset();
    a_valid = 1'b1; a_data = 8'hA5;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      a_valid = 1'b0;
      checks++;
      if (a_done !== 1'b0) begin
        failures++; $display("FAIL midrst_nodone cyc=%0d got done=%b want 0", c, a_done);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a_code, a_blank, a_busy, a_done, a_ready} !== {5'h00, 4'b1001}) begin
      failures++;
      $display("FAIL midrst got code=%h blank=%b busy=%b done=%b ready=%b want 00 1 0 0 1",
               a_code, a_blank, a_busy, a_done, a_ready);
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if ({a_done, a_busy} !== 2'b00) begin
        failures++; $display("FAIL midrst_quiet got done=%b busy=%b want 0 0", a_done, a_busy);
      end
    end
  endtask

  task automatic test_nogap_b(input logic [15:0] v);
    exp_q.delete();
    build_exp(16, 4, 0, v, 1'b0);
    b_valid = 1'b1; b_data = v;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      b_valid = 1'b0;
      checks++;
      if ({b_code, b_blank, b_done, b_ready, b_busy} !==
          {exp_q[c].code, exp_q[c].blank, exp_q[c].done, exp_q[c].done, 1'b1}) begin
        failures++;
        $display("FAIL nogap v=%h cyc=%0d got code=%h blank=%b done=%b ready=%b busy=%b want code=%h blank=%b done=%b",
                 v, c + 1, b_code, b_blank, b_done, b_ready, b_busy, exp_q[c].code, exp_q[c].blank, exp_q[c].done);
      end
    end
    @(negedge clk);
    checks++;
    if ({b_blank, b_busy, b_ready} !== 3'b101) begin
      failures++; $display("FAIL nogap_idle got blank=%b busy=%b ready=%b want 1 0 1", b_blank, b_busy, b_ready);
    end
  endtask

  task automatic test_hold1_c(input logic [7:0] v);
    exp_q.delete();
    build_exp(8, 1, 0, {8'h00, v}, 1'b0);
    c_valid = 1'b1; c_data = v;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      c_valid = 1'b0;
      checks++;
      if ({c_code, c_blank, c_done, c_ready, c_busy} !==
          {exp_q[c].code, exp_q[c].blank, exp_q[c].done, exp_q[c].done, 1'b1}) begin
        failures++;
        $display("FAIL hold1 v=%h cyc=%0d got code=%h blank=%b done=%b ready=%b busy=%b want code=%h blank=%b done=%b",
                 v, c + 1, c_code, c_blank, c_done, c_ready, c_busy, exp_q[c].code, exp_q[c].blank, exp_q[c].done);
      end
    end
    @(negedge clk);
    checks++;
    if ({c_blank, c_busy, c_ready} !== 3'b101) begin
      failures++; $display("FAIL hold1_idle got blank=%b busy=%b ready=%b want 1 0 1", c_blank, c_busy, c_ready);
    end
  endtask

  // Repeat build: each pass is followed by a gap, period 12 cycles on A.
  task automatic test_repeat(input logic [7:0] v1, input logic [7:0] v2);
    exp_q.delete();
    build_exp(8, 4, 2, {8'h00, v1}, 1'b1);
    a_valid = 1'b1; a_data = v1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      a_valid = 1'b0;
      checks++;
      if ({a_code, a_blank, a_done, a_ready, a_busy} !==
          {exp_q[c % 12].code, exp_q[c % 12].blank, exp_q[c % 12].done, exp_q[c % 12].done, 1'b1}) begin
        failures++;
        $display("FAIL repeat v=%h cyc=%0d got code=%h blank=%b done=%b ready=%b busy=%b want code=%h blank=%b done=%b",
                 v1, c + 1, a_code, a_blank, a_done, a_ready, a_busy,
                 exp_q[c % 12].code, exp_q[c % 12].blank, exp_q[c % 12].done);
      end
    end
    // Cycle 34 is a done cycle: load the new value there.
    exp_q.delete();
    build_exp(8, 4, 2, {8'h00, v2}, 1'b1);
    a_valid = 1'b1; a_data = v2;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      a_valid = 1'b0;
      checks++;
      if ({a_code, a_blank, a_done, a_ready, a_busy} !==
          {exp_q[c % 12].code, exp_q[c % 12].blank, exp_q[c % 12].done, exp_q[c % 12].done, 1'b1}) begin
        failures++;
        $display("FAIL repeat_reload v=%h cyc=%0d got code=%h blank=%b done=%b ready=%b busy=%b want code=%h blank=%b done=%b",
                 v2, c + 1, a_code, a_blank, a_done, a_ready, a_busy,
                 exp_q[c % 12].code, exp_q[c % 12].blank, exp_q[c % 12].done);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef SEG_SEQ_REPEAT_EN
    test_repeat(8'h12, 8'h34);
    test_repeat(8'($urandom), 8'($urandom));
`else
    test_single_a(8'hA5);
    for (int i = 0; i < 5; i++) test_single_a(8'($urandom));
    test_back_to_back(8'hA5, 8'h3C);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_mid_reset();
    test_nogap_b(16'hBEEF);
    for (int i = 0; i < 3; i++) test_nogap_b(16'($urandom));
    test_hold1_c(8'hFF);
    for (int i = 0; i < 3; i++) test_hold1_c(8'($urandom));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
